// File: rtl/float_to_fixed_seq.sv
// Multi-cycle IEEE-754 single to signed fixed-point converter.
// The magnitude is aligned one bit per cycle; results truncate toward zero and saturate.
module float_to_fixed_seq #(
  parameter int unsigned POS_W     = 5,
  parameter logic [31:0] NAN_VALUE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      floatin,
  input  logic [POS_W-1:0] fixpointpos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             overflow,
  output logic             invalid
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StFix   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [31:0] SatPos = 32'h7FFF_FFFF;
  localparam logic [31:0] SatNeg = 32'h8000_0000;

  logic [1:0]         state_q, state_d;
  logic [31:0]        mag_q, mag_d;
  logic signed [10:0] cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [31:0]        result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               invalid_q, invalid_d;

  logic [7:0]         exp_w;
  logic [22:0]        mant_w;
  logic [23:0]        m_w;
  logic signed [10:0] k_w;
  logic               accept_w;

  assign exp_w  = floatin[30:23];
  assign mant_w = floatin[22:0];
  assign m_w    = {1'b1, mant_w};
  // k = E - 127 + F - 23; range -150..+136 fits in 11 signed bits.
  assign k_w    = $signed(11'(exp_w) + 11'(fixpointpos) - 11'd150);

  assign in_ready  = (state_q == StIdle) && !rst;
  assign accept_w  = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign invalid   = invalid_q;

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;

    case (state_q)
      StIdle: begin
        if (accept_w) begin
          sign_d     = floatin[31];
          result_d   = 32'h0;
          overflow_d = 1'b0;
          invalid_d  = 1'b0;
          state_d    = StDone;
          if (exp_w == 8'hFF) begin
            if (mant_w != 23'h0) begin
              result_d  = NAN_VALUE;
              invalid_d = 1'b1;
            end else begin
              result_d   = floatin[31] ? SatNeg : SatPos;
              overflow_d = 1'b1;
            end
          end else if (exp_w == 8'h00) begin
            result_d = 32'h0;
          end else if (k_w > 11'sd8) begin
            result_d   = floatin[31] ? SatNeg : SatPos;
            overflow_d = 1'b1;
          end else if (k_w < -11'sd23) begin
            result_d = 32'h0;
          end else begin
            mag_d   = {8'h00, m_w};
            cnt_d   = k_w;
            // Already aligned: skip the shift phase entirely.
            state_d = (k_w == 11'sd0) ? StFix : StShift;
          end
        end
      end

      StShift: begin
        if (cnt_q == 11'sd0) begin
          state_d = StFix;
        end else if (cnt_q > 11'sd0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 11'sd1;
          if (cnt_q == 11'sd1) state_d = StFix;
        end else begin
          mag_d = mag_q >> 1;
          cnt_d = cnt_q + 11'sd1;
          if (cnt_q == -11'sd1) state_d = StFix;
        end
      end

      StFix: begin
        state_d = StDone;
        if (!sign_q && mag_q[31]) begin
          result_d   = SatPos;
          overflow_d = 1'b1;
        end else if (sign_q && (mag_q == SatNeg)) begin
          result_d   = SatNeg;
          overflow_d = 1'b0;
        end else if (sign_q && mag_q[31]) begin
          result_d   = SatNeg;
          overflow_d = 1'b1;
        end else begin
          result_d = sign_q ? (~mag_q + 32'd1) : mag_q;
        end
      end

      StDone: begin
        if (out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mag_q      <= 32'h0;
      cnt_q      <= 11'sd0;
      sign_q     <= 1'b0;
      result_q   <= 32'h0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
    end
  end

endmodule

// File: doc/float_to_fixed_seq.md
Name: float_to_fixed_seq

Overview:
Multi-cycle IEEE-754 single-precision to signed fixed-point converter with valid/ready handshakes on both sides.
- Uses one 1-bit shift per cycle instead of a barrel shifter.
- Truncates toward zero, saturates on overflow, flags NaN and overflow.
- Sits downstream of the fixed-to-float path so that float operands can return to the fixed-point datapath.

Parameters:
POS_W, 5, width of fixpointpos; the fractional bit count F ranges 0..2^POS_W-1 (max 31).
NAN_VALUE, 32'h00000000, result driven when the input is NaN.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  converter can accept; equals (state==IDLE) && !rst
floatin  input  32  IEEE-754 single: sign[31], exp[30:23], mant[22:0]
fixpointpos  input  POS_W  F, number of fractional bits in the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  32  signed two's-complement fixed point, F fractional bits
overflow  output  1  result saturated (finite overflow or infinity)
invalid  output  1  input was NaN

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, result=0, overflow=0, invalid=0. Reset mid-operation abandons the conversion; no output is produced.
- Handshake:
  - Accept occurs on a rising edge with in_valid && in_ready. floatin and fixpointpos are captured at that edge.
  - in_ready stays low from accept until the result handshake completes.
  - The result handshake is a rising edge with out_valid && out_ready. On it the block returns to IDLE and drops out_valid. in_ready rises the next cycle; there is no same-cycle re-accept.
  - result, overflow and invalid hold stable while out_valid=1 && !out_ready.
- Decode at accept. E=exp, M={1,mant} (24 bits), k = E-127+F-23 (signed, at least 10 bits).
  - E==255, mant!=0: result=NAN_VALUE, invalid=1, go to DONE.
  - E==255, mant==0: sign=0 gives 0x7FFFFFFF, sign=1 gives 0x80000000; overflow=1; go to DONE.
  - E==0 (zero or denormal): result=0, go to DONE.
  - k>8: saturate as for infinity, overflow=1, go to DONE.
  - k<-23: result=0, go to DONE.
  - Otherwise: mag={8'b0,M}, cnt=k, go to SHIFT.
- States:
  - IDLE: waits for accept.
  - SHIFT: if cnt==0, go to FIX. Else if cnt>0, mag<<=1 and cnt-=1. Else mag>>=1 (logical) and cnt+=1.
  - FIX:
    - mag>=2^31 and sign=0: result=0x7FFFFFFF, overflow=1.
    - mag==2^31 and sign=1: result=0x80000000, overflow=0.
    - mag>2^31 and sign=1: result=0x80000000, overflow=1.
    - Otherwise result = sign ? -mag : mag.
    - Go to DONE.
  - DONE: out_valid=1 until the result handshake.
- Latency, counted from the accept edge:
  - Special or short-circuit cases: out_valid after 1 edge.
  - Normal path: out_valid after |k|+2 edges. Worst case is 25 edges (k=-23).
- Flags are cleared at every accept and are valid only with out_valid.
- Negative zero produces 0 with no flags.
- Rounding is truncation of the magnitude (toward zero) for both signs.

Test Plan:
- 0x40490FDB (pi), F=16 -> k=-6; result 0x0003243F, flags 0; out_valid 8 edges after accept.
- 0xC0490FDB, F=16 -> result 0xFFFCDBC1, flags 0.
- 0xCF000000 (-2^31), F=0 -> result 0x80000000, overflow=0.
- 0x4F000000, F=0 -> result 0x7FFFFFFF, overflow=1.
- 0x3F000000 (0.5), F=0 -> k=-24, so result 0 after 1 edge.
- Specials, F=8:
  - 0x00000000 -> 0.
  - 0x7FC00000 -> NAN_VALUE, invalid=1.
  - 0x7F800000 -> 0x7FFFFFFF, overflow=1.
  - 0xFF800000 -> 0x80000000, overflow=1.
  - All return out_valid after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving a second in_valid.
  - Result and flags stay stable; in_ready stays 0; the second operand is not accepted until 1 cycle after the result handshake.
  - The second conversion then proceeds normally.
- Assert rst for 1 cycle mid-SHIFT (0x40490FDB, F=16, 3 edges after accept).
  - Immediately: out_valid=0, result=0, flags 0.
  - After release: in_ready=1.
  - A fresh conversion then gives the expected result 0x0003243F.
